interrupt_controller: RTL and testbench

//  Latches edge-triggered requests from up to NUM_IRQ peripherals, applies mask and global enable,
//  and picks the highest-priority request (lowest index wins).

---
 rtl/interrupt_controller_pkg.sv | 21 ++
 rtl/interrupt_controller_if.sv | 31 +++
 rtl/interrupt_controller_irq_edge_sync.sv | 27 ++
 rtl/interrupt_controller.sv | 90 +++++++++
 tb/tb_interrupt_controller.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state codes, default
// parameters and the vector address helper.
package interrupt_controller_pkg;

  localparam int          DEF_NUM_IRQ      = 5;
  localparam logic [7:0]  DEF_VECTOR_BASE  = 8'hE0;
  localparam int          DEF_VECTOR_SHIFT = 2;
  localparam int          SEL_W            = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_VEC     = 2'd2;
  localparam logic [1:0] ST_SERVICE = 2'd3;

  // Handler address wraps modulo 256 through the 8-bit result.
  function automatic logic [7:0] vector_of(logic [7:0] base, int shift,
                                           logic [SEL_W-1:0] sel);
    return base + (8'(sel) << shift);
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Request/handshake/bus bundle between the interrupt controller (slave) and
// the control unit plus peripherals (master).
interface interrupt_controller_if #(
  parameter int NUM_IRQ = interrupt_controller_pkg::DEF_NUM_IRQ
);
  logic [NUM_IRQ-1:0] irq;
  logic [7:0]         data;
  logic               mask_load;
  logic               ei;
  logic               di;
  logic               int_ack;
  logic               int_ret;

  logic               int_req;
  logic               vector_oe;
  logic [7:0]         vector;
  logic [NUM_IRQ-1:0] int_lines;
  logic               int_active;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq, data, mask_load, ei, di, int_ack, int_ret,
    input  int_req, vector_oe, vector, int_lines, int_active, pending, mask
  );

  modport slave (
    input  irq, data, mask_load, ei, di, int_ack, int_ret,
    output int_req, vector_oe, vector, int_lines, int_active, pending, mask
  );
endinterface

// File: rtl/interrupt_controller_irq_edge_sync.sv
// Three-flop synchronizer for one asynchronous request line, producing a
// single-cycle pulse on each rising edge.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic edge_out
);
  logic sync1, sync2, sync3;

  // NOTE: non-blocking assignments make the three flops shift together; with
  // blocking ones the chain would collapse into a single register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Flops clear in reset, so a line held high through reset yields one edge.
  assign edge_out = sync2 & ~sync3;
endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, maskable, fixed-priority interrupt controller with an
// int_req/int_ack handshake and vector drive; one handler in service at a time.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int         NUM_IRQ      = DEF_NUM_IRQ,
  parameter logic [7:0] VECTOR_BASE  = DEF_VECTOR_BASE,
  parameter int         VECTOR_SHIFT = DEF_VECTOR_SHIFT
) (
  input  logic                 clk,
  input  logic                 rst,
  interrupt_controller_if.slave bus
);
  logic [1:0]         state;
  logic [SEL_W-1:0]   sel;
  logic               ie;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edges;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clear;
  logic [SEL_W-1:0]   first_idx;
  logic               in_service;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .in       (bus.irq[i]),
      .edge_out (edges[i])
    );
  end

  assign eligible  = pending & mask;
  assign ack_clear = (state == ST_REQ && bus.int_ack) ? (NUM_IRQ'(1) << sel) : '0;

  // NOTE: first_idx gets a default before the loop so every path assigns it
  // and no latch is inferred.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) first_idx = SEL_W'(i);
    end
  end

  // NOTE: reset is synchronous and active-high, so it is tested inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= '0;
      ie      <= 1'b0;
      pending <= '0;
      mask    <= '0;
    end else begin
      // A new edge on the line being acknowledged survives the clear.
      pending <= (pending & ~ack_clear) | edges;

      if (bus.mask_load) mask <= bus.data[NUM_IRQ-1:0];

      if (bus.di)      ie <= 1'b0;
      else if (bus.ei) ie <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ie && |eligible) begin
            state <= ST_REQ;
            sel   <= first_idx;
          end
        end
        ST_REQ: begin
          if (bus.int_ack)              state <= ST_VEC;
          else if (!ie || !mask[sel])   state <= ST_IDLE;
        end
        ST_VEC:     state <= ST_SERVICE;
        ST_SERVICE: if (bus.int_ret) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign in_service     = (state == ST_VEC) || (state == ST_SERVICE);
  assign bus.int_req    = (state == ST_REQ);
  assign bus.vector_oe  = (state == ST_VEC);
  assign bus.vector     = bus.vector_oe ? vector_of(VECTOR_BASE, VECTOR_SHIFT, sel) : 8'h00;
  assign bus.int_lines  = in_service ? (NUM_IRQ'(1) << sel) : '0;
  assign bus.int_active = in_service;
  assign bus.pending    = pending;
  assign bus.mask       = mask;
endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: directed scenarios followed by
// randomized request/mask rounds checked against a set-based priority model.
module tb_interrupt_controller;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_IRQ(N)) bus ();

  interrupt_controller #(
    .NUM_IRQ      (N),
    .VECTOR_BASE  (8'hE0),
    .VECTOR_SHIFT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0]   vec;
    logic [N-1:0] lines;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic exp_t expect_for(int idx);
    exp_t e;
    e.vec   = 8'hE0 + 8'(idx * 4);
    e.lines = N'(1) << idx;
    return e;
  endfunction

  // Monitor: every cycle with vector_oe consumes one scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.vector_oe) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vector: got %0h expected none", bus.vector);
          end else begin
            mon_e = exp_q.pop_front();
            check("vector", bus.vector, mon_e.vec);
            check("vector_lines", bus.int_lines, mon_e.lines);
          end
        end else begin
          check("vector_idle", bus.vector, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ei();
    bus.ei = 1'b1; cyc(1); bus.ei = 1'b0;
  endtask

  task automatic pulse_di();
    bus.di = 1'b1; cyc(1); bus.di = 1'b0;
  endtask

  task automatic load_mask(logic [N-1:0] m);
    bus.data = 8'(m); bus.mask_load = 1'b1; cyc(1); bus.mask_load = 1'b0;
    m_mask = m;
  endtask

  task automatic raise(logic [N-1:0] b);
    bus.irq = '0;
    cyc(3);
    bus.irq = b;
    m_pend |= b;
  endtask

  task automatic wait_req(int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (bus.int_req) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic service(int idx, int budget);
    bit seen;
    wait_req(budget, seen);
    check("int_req_seen", 32'(seen), 1);
    if (!seen) return;
    exp_q.push_back(expect_for(idx));
    bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
    m_pend[idx] = 1'b0;
    cyc(1);
    check("active_in_service", bus.int_active, 1);
    check("lines_in_service", bus.int_lines, 32'(N'(1) << idx));
    cyc($urandom_range(0, 3));
    bus.int_ret = 1'b1; cyc(1); bus.int_ret = 1'b0;
    check("active_after_ret", bus.int_active, 0);
    check("lines_after_ret", bus.int_lines, 0);
  endtask

  initial begin
    bit seen;
    logic [N-1:0] v;

    rst = 1'b1;
    bus.irq = '0; bus.data = '0; bus.mask_load = 1'b0;
    bus.ei = 1'b0; bus.di = 1'b0; bus.int_ack = 1'b0; bus.int_ret = 1'b0;
    m_pend = '0; m_mask = '0;

    // Reset state
    cyc(2);
    check("rst_int_req", bus.int_req, 0);
    check("rst_vector", bus.vector, 0);
    check("rst_mask", bus.mask, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_int_lines", bus.int_lines, 0);
    rst = 1'b0;
    cyc(1);

    // Single request on line 2
    load_mask(5'h1F);
    pulse_ei();
    raise(5'b00100);
    wait_req(4, seen);
    check("req_latency", 32'(seen), 1);
    service(2, 10);

    // Simultaneous requests: lower index served first
    raise(5'b01010);
    cyc(4);
    check("prio_pending", bus.pending, 5'b01010);
    service(lowest(m_pend & m_mask), 10);
    service(lowest(m_pend & m_mask), 10);
    cyc(2);
    check("prio_pending_end", bus.pending, 0);

    // Masked request waits until the mask opens
    load_mask(5'h1E);
    pulse_ei();
    raise(5'b00001);
    cyc(6);
    check("mask_pending", bus.pending, 5'b00001);
    check("mask_no_req", bus.int_req, 0);
    load_mask(5'h1F);
    service(0, 10);

    // Withdraw by di while in REQ
    raise(5'b01000);
    wait_req(10, seen);
    check("wd_req", 32'(seen), 1);
    pulse_di();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!bus.int_req) begin seen = 1'b1; break; end
      cyc(1);
    end
    check("wd_req_dropped", 32'(seen), 1);
    check("wd_pending_kept", bus.pending, 5'b01000);
    pulse_ei();
    service(3, 10);

    // ei and di together leave interrupts disabled
    bus.ei = 1'b1; bus.di = 1'b1; cyc(1); bus.ei = 1'b0; bus.di = 1'b0;
    raise(5'b10000);
    cyc(8);
    check("eidi_no_req", bus.int_req, 0);
    check("eidi_pending", bus.pending, 5'b10000);
    pulse_ei();
    service(4, 10);

    // Reset while a handler is in service; irq[2] stays high across it
    raise(5'b00100);
    wait_req(10, seen);
    check("abort_req", 32'(seen), 1);
    exp_q.push_back(expect_for(2));
    bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
    cyc(1);
    check("abort_in_service", bus.int_active, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("abort_active", bus.int_active, 0);
    check("abort_lines", bus.int_lines, 0);
    check("abort_pending", bus.pending, 0);
    check("abort_mask", bus.mask, 0);
    check("abort_vector_oe", bus.vector_oe, 0);
    m_pend = 5'b00100;
    m_mask = '0;
    cyc(4);
    check("abort_edge_after_rst", bus.pending, m_pend);

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      pulse_di();
      cyc(1);
      v = N'($urandom_range(0, (1 << N) - 1));
      raise(v);
      cyc(4);
      check("round_pending", bus.pending, m_pend);
      load_mask(N'($urandom_range(0, (1 << N) - 1)));
      pulse_ei();
      while ((m_pend & m_mask) != '0) service(lowest(m_pend & m_mask), 10);
      cyc(4);
      check("round_no_req", bus.int_req, 0);
      check("round_pending_after", bus.pending, m_pend);
      check("round_mask", bus.mask, m_mask);
    end

    cyc(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
